// File: rtl/tt_um_pchri03_counter_checker_if.sv
// Pin bundle of the counter-checker tile: enable, stream input, control byte and the three output bytes.
// Handshake: there is no valid/ready pair; ena acts as the per-cycle valid for ui_in, and the checker is always ready.
interface tt_um_pchri03_counter_checker_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_pchri03_counter_checker.sv
// Checks that an incoming 8-bit count stream increments by one per enabled cycle,
// locking onto it, counting sequence errors and flagging loss of lock.
module tt_um_pchri03_counter_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic clk,
    input  logic rst_n,
    tt_um_pchri03_counter_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HUNT   = 2'b01,
        LOCKED = 2'b10
    } state_e;

    state_e     state_q;
    logic [7:0] prev_q;
    logic [3:0] match_cnt_q;
    logic [3:0] miss_cnt_q;
    logic [7:0] error_cnt_q;
    logic [7:0] lock_events_q;
    logic       lost_q;
    logic       err_pulse_q;

    logic [7:0] expect_d;
    logic [3:0] miss_cnt_d;
    logic       is_match;
    logic       locked;
    logic       clear;
    logic [1:0] view_sel;
    logic [3:0] cnt_view;
    logic       unused_uio;

    assign expect_d   = prev_q + 8'd1;
    assign miss_cnt_d = miss_cnt_q + 4'd1;
    assign is_match   = (bus.ui_in == expect_d);
    assign locked     = (state_q == LOCKED);
    assign clear      = bus.uio_in[0];
    assign view_sel   = bus.uio_in[2:1];
    assign unused_uio = ^bus.uio_in[7:3];
    assign cnt_view   = locked ? miss_cnt_q : match_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prev_q        <= 8'h00;
            match_cnt_q   <= 4'd0;
            miss_cnt_q    <= 4'd0;
            error_cnt_q   <= 8'h00;
            lock_events_q <= 8'h00;
            lost_q        <= 1'b0;
            err_pulse_q   <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.ena) begin
                case (state_q)
                    IDLE: begin
                        prev_q      <= bus.ui_in;
                        match_cnt_q <= 4'd0;
                        state_q     <= HUNT;
                    end
                    HUNT: begin
                        prev_q <= bus.ui_in;
                        if (is_match) begin
                            if (match_cnt_q == 4'(LOCK_COUNT - 1)) begin
                                state_q     <= LOCKED;
                                match_cnt_q <= 4'd0;
                                miss_cnt_q  <= 4'd0;
                                if (lock_events_q != 8'hFF) begin
                                    lock_events_q <= lock_events_q + 8'd1;
                                end
                            end else begin
                                match_cnt_q <= match_cnt_q + 4'd1;
                            end
                        end else begin
                            match_cnt_q <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (is_match) begin
                            prev_q     <= bus.ui_in;
                            miss_cnt_q <= 4'd0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (error_cnt_q != 8'hFF) begin
                                error_cnt_q <= error_cnt_q + 8'd1;
                            end
                            if (miss_cnt_d == 4'(LOSS_COUNT)) begin
                                state_q     <= HUNT;
                                lost_q      <= 1'b1;
                                prev_q      <= bus.ui_in;
                                miss_cnt_q  <= 4'd0;
                                match_cnt_q <= 4'd0;
                            end else begin
                                // Free-run the expectation so one glitched sample costs one error.
                                prev_q     <= expect_d;
                                miss_cnt_q <= miss_cnt_d;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // Placed last so it overrides any same-cycle error or loss update.
            if (clear) begin
                error_cnt_q <= 8'h00;
                lost_q      <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.uo_out = 8'h00;
        case (view_sel)
            2'b00:   bus.uo_out = error_cnt_q;
            2'b01:   bus.uo_out = prev_q;
            2'b10:   bus.uo_out = {lost_q, locked, state_q, cnt_view};
            default: bus.uo_out = lock_events_q;
        endcase
    end

    assign bus.uio_out = {locked, err_pulse_q, state_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_pchri03_counter_checker.sv
// Directed bench for the counter checker: a vector table of stimulus with hand-computed views,
// plus a hand-written mid-lock reset sequence.
module tb_tt_um_pchri03_counter_checker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_um_pchri03_counter_checker_if bus ();

    tt_um_pchri03_counter_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       ena;
        logic       clr;
        logic [7:0] ui;
        logic [7:0] e_err;
        logic [7:0] e_prev;
        logic [7:0] e_stat;
        logic [7:0] e_lev;
        logic [7:0] e_uio;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ena, input logic clr, input logic [7:0] ui,
                       input logic [7:0] e_err, input logic [7:0] e_prev,
                       input logic [7:0] e_stat, input logic [7:0] e_lev,
                       input logic [7:0] e_uio);
        vec_t v;
        v.ena = ena; v.clr = clr; v.ui = ui;
        v.e_err = e_err; v.e_prev = e_prev; v.e_stat = e_stat;
        v.e_lev = e_lev; v.e_uio = e_uio;
        tbl.push_back(v);
    endtask

    // Walks the four views between clock edges, then checks the status pins.
    task automatic check_views(input string tag, input logic [7:0] e_err, input logic [7:0] e_prev,
                               input logic [7:0] e_stat, input logic [7:0] e_lev,
                               input logic [7:0] e_uio);
        logic [7:0] ev [4];
        ev[0] = e_err; ev[1] = e_prev; ev[2] = e_stat; ev[3] = e_lev;
        for (int s = 0; s < 4; s++) begin
            bus.uio_in = {5'b00000, 2'(s), 1'b0};
            #1;
            check($sformatf("%s view%0d", tag, s), bus.uo_out, ev[s]);
        end
        check($sformatf("%s uio_out", tag), bus.uio_out, e_uio);
        check($sformatf("%s uio_oe", tag), bus.uio_oe, 8'hF0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        bus.ena    = v.ena;
        bus.ui_in  = v.ui;
        bus.uio_in = {7'b0000000, v.clr};
        @(posedge clk);
        #1;
        check_views(tag, v.e_err, v.e_prev, v.e_stat, v.e_lev, v.e_uio);
    endtask

    initial begin
        vec_t v;

        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_views("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Acquire: IDLE capture of 00, then four +1 matches lock on 04.
        add(1, 0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h10);
        add(1, 0, 8'h01, 8'h00, 8'h01, 8'h11, 8'h00, 8'h10);
        add(1, 0, 8'h02, 8'h00, 8'h02, 8'h12, 8'h00, 8'h10);
        add(1, 0, 8'h03, 8'h00, 8'h03, 8'h13, 8'h00, 8'h10);
        add(1, 0, 8'h04, 8'h00, 8'h04, 8'h60, 8'h01, 8'hA0);
        for (int i = 8'h05; i <= 8'h10; i++) begin
            add(1, 0, 8'(i), 8'h00, 8'(i), 8'h60, 8'h01, 8'hA0);
        end
        // Single glitch while locked.
        add(1, 0, 8'h11, 8'h00, 8'h11, 8'h60, 8'h01, 8'hA0);
        add(1, 0, 8'h55, 8'h01, 8'h12, 8'h61, 8'h01, 8'hE0);
        add(1, 0, 8'h13, 8'h01, 8'h13, 8'h60, 8'h01, 8'hA0);
        add(1, 0, 8'h14, 8'h01, 8'h14, 8'h60, 8'h01, 8'hA0);
        for (int i = 8'h15; i <= 8'h21; i++) begin
            add(1, 0, 8'(i), 8'h01, 8'(i), 8'h60, 8'h01, 8'hA0);
        end
        // Jump in the stream: three misses drop lock, then relock on 86.
        add(1, 0, 8'h80, 8'h02, 8'h22, 8'h61, 8'h01, 8'hE0);
        add(1, 0, 8'h81, 8'h03, 8'h23, 8'h62, 8'h01, 8'hE0);
        add(1, 0, 8'h82, 8'h04, 8'h82, 8'h90, 8'h01, 8'h50);
        add(1, 0, 8'h83, 8'h04, 8'h83, 8'h91, 8'h01, 8'h10);
        add(1, 0, 8'h84, 8'h04, 8'h84, 8'h92, 8'h01, 8'h10);
        add(1, 0, 8'h85, 8'h04, 8'h85, 8'h93, 8'h01, 8'h10);
        add(1, 0, 8'h86, 8'h04, 8'h86, 8'hE0, 8'h02, 8'hA0);
        // Second loss, relock at FD and run through the FF->00 wrap.
        add(1, 0, 8'h00, 8'h05, 8'h87, 8'hE1, 8'h02, 8'hE0);
        add(1, 0, 8'h00, 8'h06, 8'h88, 8'hE2, 8'h02, 8'hE0);
        add(1, 0, 8'hF9, 8'h07, 8'hF9, 8'h90, 8'h02, 8'h50);
        add(1, 0, 8'hFA, 8'h07, 8'hFA, 8'h91, 8'h02, 8'h10);
        add(1, 0, 8'hFB, 8'h07, 8'hFB, 8'h92, 8'h02, 8'h10);
        add(1, 0, 8'hFC, 8'h07, 8'hFC, 8'h93, 8'h02, 8'h10);
        add(1, 0, 8'hFD, 8'h07, 8'hFD, 8'hE0, 8'h03, 8'hA0);
        add(1, 0, 8'hFE, 8'h07, 8'hFE, 8'hE0, 8'h03, 8'hA0);
        add(1, 0, 8'hFF, 8'h07, 8'hFF, 8'hE0, 8'h03, 8'hA0);
        add(1, 0, 8'h00, 8'h07, 8'h00, 8'hE0, 8'h03, 8'hA0);
        add(1, 0, 8'h01, 8'h07, 8'h01, 8'hE0, 8'h03, 8'hA0);
        // Miss, then ena=0 for five cycles: everything holds, pulse drops.
        add(1, 0, 8'h77, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hE0);
        add(0, 0, 8'h03, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hA0);
        add(0, 0, 8'hAA, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hA0);
        add(0, 0, 8'h02, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hA0);
        add(0, 0, 8'h00, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hA0);
        add(0, 0, 8'hFF, 8'h08, 8'h02, 8'hE1, 8'h03, 8'hA0);
        // Clear coinciding with a locked miss: counter and lost zeroed, pulse still fires.
        add(1, 1, 8'h99, 8'h00, 8'h03, 8'h62, 8'h03, 8'hE0);
        add(1, 0, 8'h04, 8'h00, 8'h04, 8'h60, 8'h03, 8'hA0);
        // Clear still acts while ena=0.
        add(1, 0, 8'h50, 8'h01, 8'h05, 8'h61, 8'h03, 8'hE0);
        add(0, 1, 8'h06, 8'h00, 8'h05, 8'h61, 8'h03, 8'hA0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // One-cycle reset in the middle of a lock; clear and ena asserted to show reset wins.
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h07;
        bus.uio_in = 8'h01;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_views("midreset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        v.ena = 1; v.clr = 0; v.ui = 8'h42;
        v.e_err = 8'h00; v.e_prev = 8'h42; v.e_stat = 8'h10; v.e_lev = 8'h00; v.e_uio = 8'h10;
        apply(v, "postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
